// File: rtl/lsu_dmem_master.sv
// lsu_dmem_master: load/store initiator for a data memory with 1-cycle registered read
module lsu_dmem_master #(
  parameter int ADD_WIDTH = 18
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_add,
  output logic [3:0]  mem_wen,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [31:0] addr_q, ld_c;
  logic [1:0]  off_q, o;
  logic [2:0]  f3_q;
  logic        accept, is_h, is_w, f3_ok, err, st_ok;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  assign o          = req_addr[1:0];
  assign req_ready  = reset & (state == IDLE);
  assign accept     = req_valid & req_ready;
  assign resp_valid = state == RESP;
  assign mem_add    = !reset ? 32'h0 : (state == IDLE ? req_addr : addr_q);
  always_comb begin
    is_h  = req_funct3[1:0] == 2'b01;
    is_w  = req_funct3[1:0] == 2'b10;
    f3_ok = req_funct3[1:0] != 2'b11 && (req_we ? !req_funct3[2] : req_funct3 != 3'b110);
    err   = !f3_ok | (is_h & o[0]) | (is_w & |o) | (|req_addr[31:ADD_WIDTH]);
    st_ok = accept & req_we & !err;
    mem_wen   = !st_ok ? 4'h0 : is_w ? 4'hf : is_h ? 4'b0011 << o : 4'b0001 << o;
    mem_wdata = !st_ok ? 32'h0 : is_w ? req_wdata : is_h ? {2{req_wdata[15:0]}} : {4{req_wdata[7:0]}};
  end
  // Load lane select uses the offset/width captured at accept; funct3[2] marks zero-extension.
  always_comb begin
    ld_b = mem_rdata[{off_q, 3'b000} +: 8];
    ld_h = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_c = f3_q[1] ? mem_rdata :
           f3_q[0] ? {{16{!f3_q[2] & ld_h[15]}}, ld_h} : {{24{!f3_q[2] & ld_b[7]}}, ld_b};
  end
  always_comb begin
    state_nx = state;
    if (state == IDLE && accept) state_nx = (err | req_we) ? RESP : RD_WAIT;
    else if (state == RD_WAIT)   state_nx = RESP;
    else if (state == RESP && resp_ready) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      addr_q     <= 32'h0;
      off_q      <= 2'b00;
      f3_q       <= 3'b000;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        addr_q     <= req_addr;
        off_q      <= o;
        f3_q       <= req_funct3;
        resp_rdata <= 32'h0;
        resp_err   <= err;
      end
      if (state == RD_WAIT) resp_rdata <= ld_c;
    end
  end
endmodule

// File: tb/tb_lsu_dmem_master.sv
// tb_lsu_dmem_master: scoreboard bench for lsu_dmem_master with a behavioural data memory
module tb_lsu_dmem_master;
  logic        clk = 1'b0, reset = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata, mem_add, mem_wdata, mem_rdata;
  logic [3:0]  mem_wen;
  logic [31:0] mem [0:255];
  logic [32:0] sb [$];
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  lsu_dmem_master #(.ADD_WIDTH(18)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_add(mem_add), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    mem_rdata <= mem[mem_add[9:2]];
    for (int i = 0; i < 4; i++)
      if (mem_wen[i]) mem[mem_add[9:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ewen,
                        input logic [31:0] ewd, input logic [31:0] erd, input logic eerr,
                        input int hold);
    int lat;
    logic [32:0] e;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    resp_ready = 1'b0;
    #1;
    check({tag, ":ready"}, req_ready, 1);
    check({tag, ":wen_T"}, mem_wen, ewen);
    if (ewen != 4'h0) check({tag, ":wdata_T"}, mem_wdata, ewd);
    check({tag, ":add_T"}, mem_add, a);
    sb.push_back({eerr, erd});
    @(posedge clk);
    #1 req_valid = 1'b0; req_addr = 32'hFFFF_FFFC; req_wdata = 32'h0;
    lat = 1;
    @(negedge clk);
    while (!resp_valid && lat < 10) begin
      check({tag, ":wen_wait"}, mem_wen, 0);
      check({tag, ":add_hold"}, mem_add, a);
      lat++;
      @(negedge clk);
    end
    check({tag, ":latency"}, lat, (we || eerr) ? 1 : 2);
    for (int i = 0; i < hold; i++) begin
      check({tag, ":bp_valid"}, resp_valid, 1);
      check({tag, ":bp_rdata"}, resp_rdata, erd);
      check({tag, ":bp_err"}, resp_err, eerr);
      check({tag, ":bp_ready"}, req_ready, 0);
      check({tag, ":bp_wen"}, mem_wen, 0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    if (resp_valid && sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, ":rdata"}, resp_rdata, e[31:0]);
      check({tag, ":err"}, resp_err, e[32]);
    end else check({tag, ":resp_valid"}, resp_valid, 1);
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    check({tag, ":valid_drop"}, resp_valid, 0);
    check({tag, ":ready_after"}, req_ready, 1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    req_addr = 32'h0000_0104;
    #1;
    check("rst:valid", resp_valid, 0);
    check("rst:rdata", resp_rdata, 0);
    check("rst:err", resp_err, 0);
    check("rst:wen", mem_wen, 0);
    check("rst:add", mem_add, 0);
    check("rst:wdata", mem_wdata, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    do_req("SW",   1, 3'b010, 32'h100, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 32'h0, 0, 0);
    do_req("LW",   0, 3'b010, 32'h100, 32'h0, 4'b0, 32'h0, 32'hDEADBEEF, 0, 0);
    do_req("LB",   0, 3'b000, 32'h103, 32'h0, 4'b0, 32'h0, 32'hFFFFFFDE, 0, 0);
    do_req("LBU",  0, 3'b100, 32'h103, 32'h0, 4'b0, 32'h0, 32'h000000DE, 0, 0);
    do_req("LH",   0, 3'b001, 32'h102, 32'h0, 4'b0, 32'h0, 32'hFFFFDEAD, 0, 0);
    do_req("LHU",  0, 3'b101, 32'h100, 32'h0, 4'b0, 32'h0, 32'h0000BEEF, 0, 0);
    do_req("SB",   1, 3'b000, 32'h101, 32'h12345655, 4'b0010, 32'h55555555, 32'h0, 0, 0);
    do_req("LBU1", 0, 3'b100, 32'h101, 32'h0, 4'b0, 32'h0, 32'h00000055, 0, 0);
    do_req("SH",   1, 3'b001, 32'h102, 32'h0000ABCD, 4'b1100, 32'hABCDABCD, 32'h0, 0, 0);
    do_req("LWbp", 0, 3'b010, 32'h100, 32'h0, 4'b0, 32'h0, 32'hABCD55EF, 0, 3);
    do_req("LB0",  0, 3'b000, 32'h100, 32'h0, 4'b0, 32'h0, 32'hFFFFFFEF, 0, 0);
    do_req("E_LW", 0, 3'b010, 32'h102, 32'h0, 4'b0, 32'h0, 32'h0, 1, 0);
    do_req("E_SH", 1, 3'b001, 32'h101, 32'h1111, 4'b0, 32'h0, 32'h0, 1, 0);
    do_req("E_F3", 0, 3'b011, 32'h100, 32'h0, 4'b0, 32'h0, 32'h0, 1, 0);
    do_req("E_OOR",0, 3'b010, 32'h40000, 32'h0, 4'b0, 32'h0, 32'h0, 1, 0);
    do_req("E_SF4",1, 3'b100, 32'h100, 32'h5, 4'b0, 32'h0, 32'h0, 1, 2);
    do_req("E_LH", 0, 3'b001, 32'h103, 32'h0, 4'b0, 32'h0, 32'h0, 1, 0);
    do_req("LWchk",0, 3'b010, 32'h100, 32'h0, 4'b0, 32'h0, 32'hABCD55EF, 0, 0);

    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("mid:ready_rdwait", req_ready, 0);
    reset = 1'b0;
    #1;
    check("mid:valid", resp_valid, 0);
    check("mid:add", mem_add, 0);
    check("mid:wen", mem_wen, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mid:no_stale", resp_valid, 0);
      check("mid:ready", req_ready, 1);
    end
    do_req("post", 0, 3'b101, 32'h102, 32'h0, 4'b0, 32'h0, 32'h0000ABCD, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
